// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display path: display-register field
// layout, MMIO address and the hex-to-segment lookup.
package seg7_pkg;

    localparam int HEX_LSB    = 0;
    localparam int DP_LSB     = 16;
    localparam int EN_LSB     = 20;
    localparam int RAW_BIT    = 31;
    localparam int NUM_DIGITS = 4;

    localparam logic [6:0]  SEG_OFF       = 7'h7F;
    localparam logic [31:0] DISP_REG_ADDR = 32'h4000_0014;

    // Only the fields the scanner consumes are kept in the active copy.
    typedef struct packed {
        logic        raw;
        logic [3:0]  en;
        logic [3:0]  dp;
        logic [15:0] hex;
    } disp_word_t;

    function automatic disp_word_t unpack_word(input logic [31:0] w);
        disp_word_t d;
        d.raw = w[RAW_BIT];
        d.en  = w[EN_LSB +: 4];
        d.dp  = w[DP_LSB +: 4];
        d.hex = w[HEX_LSB +: 16];
        return d;
    endfunction

    // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// CPU-side store/readback port of the display register (decoded MMIO slot).
interface seg7_scan_driver_if;

    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (
        output wr_en,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        output rd_data
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder, shared by display blocks.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode scanner with double-buffered display register and raw bypass.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES = 25000,
    parameter int BLANK_CYCLES = 250
) (
    input  logic                 clk,
    input  logic                 reset,
    seg7_scan_driver_if.slave    bus,
    input  logic [11:0]          raw_digi,
    output logic [11:0]          digi,
    output logic                 frame_done
);

    localparam int DIV_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIGIT_CYCLES - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [31:0]      pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    disp_word_t       active_q, active_d;
    logic [11:0]      digi_q, digi_d;

    logic             wrap;
    logic             boundary;
    logic             in_blank;
    logic [6:0]       digit_seg [NUM_DIGITS];
    logic [3:0]       an_on;

    assign wrap     = (div_q == DIV_LAST);
    assign boundary = wrap && (idx_q == 2'd3);
    assign in_blank = (div_q < BLANK_END);

    // One decoder per digit; the scan index just selects among them.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic suppress;

            seg7_decode u_dec (
                .nibble (active_q.hex[4*gi +: 4]),
                .seg    (digit_seg[gi])
            );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (gi == 0) begin : g_keep
                assign suppress = 1'b0;
            end else begin : g_lz
                assign suppress = (active_q.hex[15:4*gi] == '0);
            end
`else
            assign suppress = 1'b0;
`endif

            assign an_on[gi] = (idx_q == 2'(gi)) && active_q.en[gi]
                               && !in_blank && !suppress;
        end
    endgenerate

    always_comb begin
        div_d = wrap ? '0 : div_q + DIV_W'(1);
        idx_d = wrap ? idx_q + 2'd1 : idx_q;
    end

    // Double buffer: the boundary commits the old pending word before a
    // same-cycle store lands, so such a store waits for the next frame.
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        active_d   = active_q;
        if (boundary && pend_vld_q) begin
            active_d   = unpack_word(pend_q);
            pend_vld_d = 1'b0;
        end
        if (bus.wr_en) begin
            pend_d     = bus.wr_data;
            pend_vld_d = 1'b1;
        end
    end

    always_comb begin
        if (active_q.raw) begin
            digi_d = raw_digi;
        end else begin
            digi_d = {~an_on, ~active_q.dp[idx_q], digit_seg[idx_q]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= '0;
            idx_q      <= 2'd0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            active_q   <= '0;
            digi_q     <= 12'hFFF;
        end else begin
            div_q      <= div_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            active_q   <= active_d;
            digi_q     <= digi_d;
        end
    end

    assign digi        = digi_q;
    assign frame_done  = boundary;
    assign bus.rd_data = pend_q;

endmodule
